// File: rtl/parking_management_system.sv
// Two-pool car park occupancy tracker (university and general pools).
// Define PARKING_EDGE_DETECT_EN to count strobes on 0->1 transitions instead of per high cycle.
module parking_management_system #(
  parameter int unsigned UNI_CAPACITY = 500,
  parameter int unsigned GEN_CAPACITY = 200,
  parameter int unsigned CNT_W        = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_entered,
  input  logic             car_exited,
  input  logic             is_uni_car_entered,
  input  logic             is_uni_car_exited,
  output logic [CNT_W-1:0] uni_parked_car,
  output logic [CNT_W-1:0] parked_car,
  output logic [CNT_W-1:0] uni_vacated_space,
  output logic [CNT_W-1:0] vacated_space,
  output logic             uni_is_vacated_space,
  output logic             is_vacated_space
);

  localparam logic [CNT_W-1:0] UniCap = CNT_W'(UNI_CAPACITY);
  localparam logic [CNT_W-1:0] GenCap = CNT_W'(GEN_CAPACITY);

  logic entry_ev;
  logic exit_ev;

`ifdef PARKING_EDGE_DETECT_EN
  logic entered_q;
  logic exited_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entered_q <= 1'b0;
      exited_q  <= 1'b0;
    end else begin
      entered_q <= car_entered;
      exited_q  <= car_exited;
    end
  end

  assign entry_ev = car_entered & ~entered_q;
  assign exit_ev  = car_exited & ~exited_q;
`else
  assign entry_ev = car_entered;
  assign exit_ev  = car_exited;
`endif

  // Same-pool entry+exit nets to zero while the pool holds cars; with an empty pool the
  // exit is meaningless, so the entry is handled on its own.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W-1:0] cap,
                                                  input logic             ent,
                                                  input logic             ext);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (ent && ext && (cnt != '0)) begin
      nxt = cnt;
    end else if (ent && (cnt < cap)) begin
      nxt = cnt + CNT_W'(1);
    end else if (ext && !ent && (cnt != '0)) begin
      nxt = cnt - CNT_W'(1);
    end
    return nxt;
  endfunction

  logic [CNT_W-1:0] uni_cnt_q, uni_cnt_d;
  logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;
  logic             uni_ent, uni_ext, gen_ent, gen_ext;

  always_comb begin
    uni_ent   = entry_ev & is_uni_car_entered;
    gen_ent   = entry_ev & ~is_uni_car_entered;
    uni_ext   = exit_ev & is_uni_car_exited;
    gen_ext   = exit_ev & ~is_uni_car_exited;
    uni_cnt_d = next_count(uni_cnt_q, UniCap, uni_ent, uni_ext);
    gen_cnt_d = next_count(gen_cnt_q, GenCap, gen_ent, gen_ext);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uni_cnt_q <= '0;
      gen_cnt_q <= '0;
    end else begin
      uni_cnt_q <= uni_cnt_d;
      gen_cnt_q <= gen_cnt_d;
    end
  end

  always_comb begin
    uni_parked_car       = uni_cnt_q;
    parked_car           = gen_cnt_q;
    uni_vacated_space    = UniCap - uni_cnt_q;
    vacated_space        = GenCap - gen_cnt_q;
    uni_is_vacated_space = (uni_vacated_space != '0);
    is_vacated_space     = (vacated_space != '0);
  end

endmodule

// File: tb/tb_parking_management_system.sv
// Bench for parking_management_system: cumulative vector table plus held-strobe and
// mid-run reset sequences.
module tb_parking_management_system;

  localparam int UniCap = 500;
  localparam int GenCap = 200;
  localparam int W      = 10;

  logic         clk;
  logic         reset;
  logic         car_entered;
  logic         car_exited;
  logic         is_uni_car_entered;
  logic         is_uni_car_exited;
  logic [W-1:0] uni_parked_car;
  logic [W-1:0] parked_car;
  logic [W-1:0] uni_vacated_space;
  logic [W-1:0] vacated_space;
  logic         uni_is_vacated_space;
  logic         is_vacated_space;

  parking_management_system #(
    .UNI_CAPACITY(UniCap),
    .GEN_CAPACITY(GenCap),
    .CNT_W       (W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .car_entered         (car_entered),
    .car_exited          (car_exited),
    .is_uni_car_entered  (is_uni_car_entered),
    .is_uni_car_exited   (is_uni_car_exited),
    .uni_parked_car      (uni_parked_car),
    .parked_car          (parked_car),
    .uni_vacated_space   (uni_vacated_space),
    .vacated_space       (vacated_space),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  ent;
    logic  ext;
    logic  uni_ent;
    logic  uni_ext;
    int    reps;
    int    exp_uni;
    int    exp_gen;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input string name, input logic ent, input logic ext, input logic uni_ent,
                     input logic uni_ext, input int reps, input int exp_uni, input int exp_gen);
    vec_t v;
    v.name = name; v.ent = ent; v.ext = ext; v.uni_ent = uni_ent; v.uni_ext = uni_ext;
    v.reps = reps; v.exp_uni = exp_uni; v.exp_gen = exp_gen;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected vacated space and flags follow from the expected parked counts.
  task automatic check_state(input string tag, input int exp_uni, input int exp_gen);
    check({tag, " uni_parked"}, int'(uni_parked_car), exp_uni);
    check({tag, " gen_parked"}, int'(parked_car), exp_gen);
    check({tag, " uni_vacated"}, int'(uni_vacated_space), UniCap - exp_uni);
    check({tag, " gen_vacated"}, int'(vacated_space), GenCap - exp_gen);
    check({tag, " uni_flag"}, int'(uni_is_vacated_space), (exp_uni != UniCap) ? 1 : 0);
    check({tag, " gen_flag"}, int'(is_vacated_space), (exp_gen != GenCap) ? 1 : 0);
  endtask

  task automatic pulse(input logic ent, input logic ext, input logic uni_ent, input logic uni_ext,
                       input int reps);
    for (int i = 0; i < reps; i++) begin
      @(negedge clk);
      car_entered = ent; car_exited = ext;
      is_uni_car_entered = uni_ent; is_uni_car_exited = uni_ext;
      @(negedge clk);
      car_entered = 1'b0; car_exited = 1'b0;
    end
  endtask

  int exp_held;

  initial begin
    car_entered = 1'b0; car_exited = 1'b0;
    is_uni_car_entered = 1'b0; is_uni_car_exited = 1'b0;
    reset = 1'b0;
    #1;
    check_state("reset_async", 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_state("after_reset", 0, 0);

    //   name               ent  ext  uent uext reps  uni  gen
    add("uni_entry",        1,   0,   1,   0,   1,    1,   0);
    add("gen_entry",        1,   0,   0,   0,   1,    1,   1);
    add("uni_exit",         0,   1,   0,   1,   1,    0,   1);
    add("gen_exit",         0,   1,   0,   0,   1,    0,   0);
    add("gen_exit_empty",   0,   1,   1,   0,   1,    0,   0);
    add("uni_exit_empty",   0,   1,   0,   1,   1,    0,   0);
    add("fill_uni",         1,   0,   1,   0,   500,  500, 0);
    add("fill_gen",         1,   0,   0,   0,   200,  500, 200);
    add("uni_entry_full",   1,   0,   1,   0,   1,    500, 200);
    add("gen_entry_full",   1,   0,   0,   0,   1,    500, 200);
    add("uni_exit_full",    0,   1,   0,   1,   1,    499, 200);
    add("gen_exit_full",    0,   1,   0,   0,   1,    499, 199);
    add("uni_refill",       1,   0,   1,   0,   1,    500, 199);
    add("gen_refill",       1,   0,   0,   0,   1,    500, 200);
    add("uni_both_full",    1,   1,   1,   1,   1,    500, 200);
    add("drain_uni",        0,   1,   0,   1,   500,  0,   200);
    add("uni_both_empty",   1,   1,   1,   1,   1,    1,   200);
    add("uni_in_gen_out",   1,   1,   1,   0,   1,    2,   199);
    add("gen_in_uni_out",   1,   1,   0,   1,   1,    1,   200);
    add("gen_both_full",    1,   1,   0,   0,   1,    1,   200);
    add("quals_no_strobe",  0,   0,   1,   1,   3,    1,   200);

    foreach (vecs[i]) begin
      pulse(vecs[i].ent, vecs[i].ext, vecs[i].uni_ent, vecs[i].uni_ext, vecs[i].reps);
      check_state(vecs[i].name, vecs[i].exp_uni, vecs[i].exp_gen);
    end

    // Held strobe from an empty pool.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    car_entered = 1'b1; is_uni_car_entered = 1'b1;
    repeat (5) @(negedge clk);
    car_entered = 1'b0;
`ifdef PARKING_EDGE_DETECT_EN
    exp_held = 1;
`else
    exp_held = 5;
`endif
    check_state("held_5", exp_held, 0);

    // Reset asserted between clock edges must clear the counts immediately.
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 3);
    check_state("pre_reset", exp_held, 3);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_state("mid_reset", 0, 0);
    @(negedge clk);
    reset = 1'b1;
    pulse(1'b1, 1'b0, 1'b1, 1'b0, 1);
    check_state("resume", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
